// File: rtl/adpll_lock_detect.sv
// adpll_lock_detect: lock detector on the ADPLL loop-filter magnitude, sampled on synchronized clk_ref rises.
// Optional sticky loss_flag is enabled by defining ADPLL_LOCK_LOSS_FLAG_EN.
module adpll_lock_detect #(
   parameter int WIDTH      = 5,
   parameter int TOL        = 2,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_ref,
   input  logic             clr,
   input  logic [WIDTH-1:0] dout,
   input  logic             sign,
   output logic             lock,
   output logic             lock_lost,
   output logic [1:0]       state,
   output logic             loss_flag
);
   typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED, HOLD} state_t;
   state_t st;
   logic ref_s1, ref_s2, ref_s3, strobe, inwin, lose, unused_sign;
   logic [7:0] acq_cnt, miss_cnt, acq_inc, miss_inc;
   assign state = st;
   assign unused_sign = sign;
   always_comb begin
      inwin    = dout <= WIDTH'(TOL);
      acq_inc  = acq_cnt == 8'hff ? acq_cnt : acq_cnt + 8'd1;
      miss_inc = miss_cnt == 8'hff ? miss_cnt : miss_cnt + 8'd1;
      lose     = strobe & ~clr & ~inwin &
                 ((st == LOCKED & UNLOCK_CNT == 1) | (st == HOLD & miss_inc == 8'(UNLOCK_CNT)));
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_s1 <= 1'b0;
         ref_s2 <= 1'b0;
         ref_s3 <= 1'b0;
         strobe <= 1'b0;
      end else begin
         ref_s1 <= clk_ref;
         ref_s2 <= ref_s1;
         ref_s3 <= ref_s2;
         strobe <= ref_s2 & ~ref_s3;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st        <= UNLOCKED;
         acq_cnt   <= '0;
         miss_cnt  <= '0;
         lock      <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         lock_lost <= lose;
         if (clr || lose) begin
            st       <= UNLOCKED;
            acq_cnt  <= '0;
            miss_cnt <= '0;
            lock     <= 1'b0;
         end else if (strobe) begin
            case (st)
               UNLOCKED: if (inwin) begin
                  acq_cnt <= 8'd1;
                  st      <= LOCK_CNT == 1 ? LOCKED : ACQUIRE;
                  lock    <= LOCK_CNT == 1;
               end
               ACQUIRE: if (!inwin) begin
                  st      <= UNLOCKED;
                  acq_cnt <= '0;
               end else begin
                  acq_cnt <= acq_inc;
                  if (acq_inc == 8'(LOCK_CNT)) begin
                     st   <= LOCKED;
                     lock <= 1'b1;
                  end
               end
               LOCKED: if (!inwin) begin
                  st       <= HOLD;
                  miss_cnt <= 8'd1;
               end
               HOLD: if (inwin) begin
                  st       <= LOCKED;
                  miss_cnt <= '0;
               end else miss_cnt <= miss_inc;
            endcase
         end
      end
   end
`ifdef ADPLL_LOCK_LOSS_FLAG_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) loss_flag <= 1'b0;
      else      loss_flag <= clr ? 1'b0 : loss_flag | lose;
   end
`else
   assign loss_flag = 1'b0;
`endif
endmodule

// File: tb/tb_adpll_lock_detect.sv
// tb_adpll_lock_detect: directed checks of acquire, hold, unlock, clear priority and LOCK_CNT=255 lock.
module tb_adpll_lock_detect;
   logic clk = 0, rst = 0, clk_ref = 0, clr = 0, sign = 0;
   logic [4:0] dout = 0;
   logic lock, lock_lost, loss_flag, lock2, lock_lost2, loss_flag2;
   logic [1:0] state, state2;
   logic [1:0] st_pre;
   int errs = 0, checks = 0;
`ifdef ADPLL_LOCK_LOSS_FLAG_EN
   localparam int LF = 1;
`else
   localparam int LF = 0;
`endif
   always #5 clk = ~clk;
   adpll_lock_detect dut (
      .clk(clk), .rst(rst), .clk_ref(clk_ref), .clr(clr), .dout(dout), .sign(sign),
      .lock(lock), .lock_lost(lock_lost), .state(state), .loss_flag(loss_flag)
   );
   adpll_lock_detect #(.LOCK_CNT(255)) dut2 (
      .clk(clk), .rst(rst), .clk_ref(clk_ref), .clr(clr), .dout(dout), .sign(sign),
      .lock(lock2), .lock_lost(lock_lost2), .state(state2), .loss_flag(loss_flag2)
   );
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   // One reference period; returns #1 after the 4th clk edge past the clk_ref rise.
   task automatic sample(input logic [4:0] d, input logic s, input logic c);
      @(negedge clk) clk_ref = 0;
      repeat (2) @(negedge clk);
      dout = d;
      sign = s;
      clk_ref = 1;
      repeat (3) @(posedge clk);
      #1 st_pre = state;
      clr = c;
      @(posedge clk);
      #1 clr = 0;
   endtask
   initial begin
      for (int i = 0; i < 8; i++) begin
         repeat (3) @(negedge clk);
         clk_ref = ~clk_ref;
      end
      chk("rst_lock", lock, 0);
      chk("rst_state", state, 0);
      chk("rst_lost", lock_lost, 0);
      chk("rst_flag", loss_flag, 0);
      @(negedge clk) clk_ref = 0;
      @(negedge clk) rst = 1;
      sample(5'd1, 1'b0, 1'b0);
      chk("first_pre", st_pre, 0);
      chk("first_state", state, 1);
      for (int i = 1; i < 15; i++) sample(5'd1, 1'b0, 1'b0);
      chk("acq15_state", state, 1);
      chk("acq15_lock", lock, 0);
      sample(5'd1, 1'b0, 1'b0);
      chk("acq16_pre", st_pre, 1);
      chk("acq16_state", state, 2);
      chk("acq16_lock", lock, 1);
      for (int i = 0; i < 3; i++) sample(5'd31, 1'b0, 1'b0);
      chk("hold3_state", state, 3);
      chk("hold3_lock", lock, 1);
      sample(5'd0, 1'b0, 1'b0);
      chk("relock_state", state, 2);
      chk("relock_lock", lock, 1);
      for (int i = 0; i < 3; i++) sample(5'd31, 1'b0, 1'b0);
      chk("miss3_state", state, 3);
      chk("miss3_lost", lock_lost, 0);
      sample(5'd31, 1'b0, 1'b0);
      chk("unlock_state", state, 0);
      chk("unlock_lock", lock, 0);
      chk("unlock_lost", lock_lost, 1);
      chk("unlock_flag", loss_flag, LF);
      @(posedge clk) #1;
      chk("lost_width", lock_lost, 0);
      for (int i = 0; i < 10; i++) sample(5'd2, 1'b1, 1'b0);
      chk("abort_pre_state", state, 1);
      sample(5'd7, 1'b0, 1'b0);
      chk("abort_state", state, 0);
      for (int i = 0; i < 15; i++) sample(5'd2, 1'b1, 1'b0);
      chk("reacq15_lock", lock, 0);
      sample(5'd2, 1'b1, 1'b0);
      chk("reacq16_lock", lock, 1);
      chk("flag_sticky", loss_flag, LF);
      sample(5'd3, 1'b0, 1'b0);
      chk("tol3_state", state, 3);
      sample(5'd2, 1'b1, 1'b0);
      chk("tol2_state", state, 2);
      for (int i = 0; i < 3; i++) sample(5'd31, 1'b0, 1'b0);
      chk("clr_pre_state", state, 3);
      sample(5'd31, 1'b0, 1'b1);
      chk("clr_state", state, 0);
      chk("clr_lock", lock, 0);
      chk("clr_lost", lock_lost, 0);
      chk("clr_flag", loss_flag, 0);
      chk("clr2_state", state2, 0);
      for (int i = 0; i < 255; i++) begin
         sample(5'd0, 1'b0, 1'b0);
         if (i == 0) chk("post_clr_state", state, 1);
         if (i == 253) begin
            chk("lc255_254_state", state2, 1);
            chk("lc255_254_lock", lock2, 0);
         end
      end
      chk("lc255_state", state2, 2);
      chk("lc255_lock", lock2, 1);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
